// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared word type, Q1.15 limits and argmax state encoding
package dnn_pkg;

  localparam int WORD_W = 16;

  typedef logic signed [WORD_W-1:0] q_t;

  localparam q_t Q_MIN = 16'sh8000;
  localparam q_t Q_MAX = 16'sh7FFF;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_SCAN,
    ST_OUT
  } argmax_state_e;

endpackage

// File: rtl/output_argmax.sv
// rtl/output_argmax.sv - captures per-neuron scores, scans for the max, presents class on valid/ready
module output_argmax
  import dnn_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CLASSES-1:0]          neuron_done,
  input  logic [WORD_W*NUM_CLASSES-1:0]   neuron_result,
  output logic                            class_valid,
  input  logic                            class_ready,
  output logic [IDX_WIDTH-1:0]            class_idx,
  output logic signed [WORD_W-1:0]        class_score,
  output logic                            busy,
  output logic                            overrun
);

  localparam logic [IDX_WIDTH-1:0] LAST_PTR = IDX_WIDTH'(NUM_CLASSES - 1);

  argmax_state_e          state_q, state_d;
  logic [NUM_CLASSES-1:0] flags_q, flags_d;
  q_t                     score_q [NUM_CLASSES];
  q_t                     score_d [NUM_CLASSES];
  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]   max_idx_q, max_idx_d;
  logic [IDX_WIDTH-1:0]   class_idx_q, class_idx_d;
  q_t                     max_q, max_d;
  q_t                     class_score_q, class_score_d;
  logic                   overrun_q, overrun_d;

  q_t   cand;
  logic cand_wins;

  // Strict greater-than keeps the earliest index on ties.
  assign cand      = score_q[ptr_q];
  assign cand_wins = cand > max_q;

  always_comb begin
    state_d       = state_q;
    flags_d       = flags_q;
    score_d       = score_q;
    ptr_d         = ptr_q;
    max_d         = max_q;
    max_idx_d     = max_idx_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    overrun_d     = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
          if (neuron_done[i]) begin
            flags_d[i] = 1'b1;
            score_d[i] = q_t'(neuron_result[WORD_W*i +: WORD_W]);
          end
        end
        if (&flags_d) begin
          state_d   = ST_SCAN;
          ptr_d     = '0;
          max_d     = Q_MIN;
          max_idx_d = '0;
        end
      end
      ST_SCAN: begin
        overrun_d = |neuron_done;
        if (cand_wins) begin
          max_d     = cand;
          max_idx_d = ptr_q;
        end
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          class_idx_d   = cand_wins ? ptr_q : max_idx_q;
          class_score_d = cand_wins ? cand : max_q;
          flags_d       = '0;
          state_d       = ST_OUT;
        end
      end
      ST_OUT: begin
        overrun_d = |neuron_done;
        if (class_ready) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_COLLECT;
      flags_q       <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) score_q[i] <= '0;
      ptr_q         <= '0;
      max_q         <= '0;
      max_idx_q     <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      score_q       <= score_d;
      ptr_q         <= ptr_d;
      max_q         <= max_d;
      max_idx_q     <= max_idx_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      overrun_q     <= overrun_d;
    end
  end

  assign class_valid = (state_q == ST_OUT);
  assign busy        = (state_q != ST_COLLECT);
  assign overrun     = overrun_q;
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;

endmodule

// File: tb/tb_output_argmax.sv
// tb/tb_output_argmax.sv - directed frames checked against a frame-level argmax model
module tb_output_argmax;
  import dnn_pkg::*;

  localparam int N  = 10;
  localparam int IW = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        neuron_done = '0;
  logic [16*N-1:0]     neuron_result = '0;
  logic                class_valid;
  logic                class_ready = 1'b0;
  logic [IW-1:0]       class_idx;
  logic signed [15:0]  class_score;
  logic                busy;
  logic                overrun;

  output_argmax #(.NUM_CLASSES(N), .IDX_WIDTH(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .neuron_done   (neuron_done),
    .neuron_result (neuron_result),
    .class_valid   (class_valid),
    .class_ready   (class_ready),
    .class_idx     (class_idx),
    .class_score   (class_score),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Frame-level model: 0 = collecting, 1 = scanning, 2 = presenting
  int  m_phase = 0;
  int  m_left  = 0;
  bit  m_flags [N];
  int  m_scores [N];
  int  m_idx   = 0;
  int  m_score = 0;
  bit  m_ov    = 1'b0;

  function automatic void m_argmax();
    int best;
    best = m_scores[0];
    for (int i = 1; i < N; i++) if (m_scores[i] > best) best = m_scores[i];
    m_score = best;
    for (int i = N - 1; i >= 0; i--) if (m_scores[i] == best) m_idx = i;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_ov    = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_flags[i]  = 1'b0;
        m_scores[i] = 0;
      end
    end else begin
      m_ov = 1'b0;
      case (m_phase)
        0: begin
          bit all_set;
          all_set = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (neuron_done[i]) begin
              m_flags[i]  = 1'b1;
              m_scores[i] = $signed(neuron_result[16*i +: 16]);
            end
            all_set = all_set & m_flags[i];
          end
          if (all_set) begin
            m_argmax();
            for (int i = 0; i < N; i++) m_flags[i] = 1'b0;
            m_phase = 1;
            m_left  = N;
          end
        end
        1: begin
          m_ov   = |neuron_done;
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
        default: begin
          m_ov = |neuron_done;
          if (class_ready) m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", class_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_idx", class_idx, 0);
      check("rst_score", class_score, 0);
    end else begin
      check("valid", class_valid, m_phase == 2);
      check("busy", busy, m_phase != 0);
      check("overrun", overrun, m_ov);
      if (m_phase == 2) begin
        check("idx", class_idx, m_idx);
        check("score", class_score, m_score);
      end
    end
  end

  logic signed [15:0] v [N];

  task automatic drive(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) neuron_result[16*i +: 16] = v[i];
    neuron_done = mask;
    @(posedge clk);
    #2;
    neuron_done = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #2;
      n++;
      if (class_valid) break;
    end
    if (!class_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic accept();
    class_ready = 1'b1;
    @(posedge clk);
    #2;
    class_ready = 1'b0;
    check("valid_drop", class_valid, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // 1: all at once, ascending
    for (int i = 0; i < N; i++) v[i] = 16'(i * 100);
    drive('1);
    wait_valid(n);
    check("t1_latency", n + 1, 11);
    check("t1_idx", class_idx, 9);
    check("t1_score", class_score, 900);
    accept();

    // 2: staggered, positive max among negatives
    for (int i = 0; i < N; i++) v[i] = 16'(-(i + 1) * 10);
    v[3] = 16'sh7FFF;
    for (int i = 0; i < N; i++) drive(N'(1) << i);
    wait_valid(n);
    check("t2_idx", class_idx, 3);
    check("t2_score", class_score, 32767);
    accept();

    // 3: tie at 2 and 7, after an overwritten early high value at 5
    for (int i = 0; i < N; i++) v[i] = 16'sh0000;
    v[5] = 16'sh7000;
    drive(N'(1) << 5);
    v[5] = 16'sh0000;
    v[2] = 16'sh4000;
    v[7] = 16'sh4000;
    drive('1);
    wait_valid(n);
    check("t3_idx", class_idx, 2);
    check("t3_score", class_score, 16384);
    accept();

    // 4: all minimum, then all negative
    for (int i = 0; i < N; i++) v[i] = 16'sh8000;
    drive('1);
    wait_valid(n);
    check("t4a_idx", class_idx, 0);
    check("t4a_score", class_score, -32768);
    accept();
    v[0] = -16'sd5; v[1] = -16'sd1;  v[2] = -16'sd9; v[3] = -16'sd3; v[4] = -16'sd7;
    v[5] = -16'sd2; v[6] = -16'sd8;  v[7] = -16'sd4; v[8] = -16'sd6; v[9] = -16'sd10;
    drive('1);
    wait_valid(n);
    check("t4b_idx", class_idx, 1);
    check("t4b_score", class_score, -1);
    accept();

    // 5: back-pressure and overrun in OUT
    for (int i = 0; i < N; i++) v[i] = 16'(i * 7 - 30);
    v[6] = 16'sd1234;
    drive('1);
    wait_valid(n);
    repeat (20) @(posedge clk);
    #2;
    check("t5_hold_valid", class_valid, 1);
    check("t5_hold_idx", class_idx, 6);
    check("t5_hold_score", class_score, 1234);
    v[0] = 16'sh7FFF;
    drive(N'(1));
    check("t5_overrun", overrun, 1);
    @(posedge clk);
    #2;
    check("t5_overrun_end", overrun, 0);
    check("t5_idx_after", class_idx, 6);
    accept();
    for (int i = 0; i < N; i++) v[i] = 16'(i);
    drive('1);
    wait_valid(n);
    check("t5b_idx", class_idx, 9);
    check("t5b_score", class_score, 9);
    accept();

    // 6: reset mid-scan, then a fresh frame
    for (int i = 0; i < N; i++) v[i] = 16'(100 - i * 3);
    v[8] = 16'sd500;
    drive('1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", class_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_idx", class_idx, 0);
    check("t6_score", class_score, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) v[i] = 16'(-2 * i);
    v[4] = 16'sd77;
    drive(N'(10'h1FF));
    repeat (3) @(posedge clk);
    #2;
    check("t6_partial_busy", busy, 0);
    drive(N'(1) << 9);
    wait_valid(n);
    check("t6_idx_fresh", class_idx, 4);
    check("t6_score_fresh", class_score, 77);
    accept();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
